// File: rtl/seg_display_capture.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment bus.
// Samples {an,seg,dp}, waits for a stable strobe, decodes the glyph and
// latches it into every selected digit position. Each digit ages and goes
// stale if it is not refreshed; undecodable glyphs are counted.
module seg_display_capture #(
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT_BITS  = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  output logic [19:0] digit_code,
  output logic [3:0]  digit_valid,
  output logic [3:0]  digit_dp,
  output logic        cap_strobe,
  output logic [3:0]  cap_sel,
  output logic [7:0]  err_cnt
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  // Capture fires on the edge where the counter moves from this value to STABLE_CYCLES-1
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [TIMEOUT_BITS-1:0] AGE_MAX  = '1;
  localparam logic [TIMEOUT_BITS-1:0] AGE_WARN = AGE_MAX - TIMEOUT_BITS'(1);
  localparam logic [4:0] CODE_BAD = 5'h1F;

  typedef enum logic {SETTLE, HELD} state_t;

  // Sample layout: {an[3:0], seg[6:0], dp}
  logic [11:0]      samp_q, prev_q;
  logic             samp_vld_q, prev_vld_q;
  state_t           state_q;
  logic [CNT_W-1:0] stab_cnt_q;
  logic             strobe_q;
  logic [3:0]       sel_q;
  logic [7:0]       err_q;

  logic             changed;
  logic             cap_go;
  logic             cap_wr;
  logic [3:0]       sel_d;
  logic [4:0]       glyph_d;

  // Register the raw bus and keep the previous sample for change detection.
  // The valid flags make the very first sample after reset look like a change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_q     <= 12'hFFE;
      prev_q     <= 12'hFFE;
      samp_vld_q <= 1'b0;
      prev_vld_q <= 1'b0;
    end else begin
      samp_q     <= {an, seg, dp};
      prev_q     <= samp_q;
      samp_vld_q <= 1'b1;
      prev_vld_q <= samp_vld_q;
    end
  end

  assign changed = samp_vld_q && (!prev_vld_q || (samp_q != prev_q));
  assign sel_d   = ~samp_q[11:8];
  // A change on the would-be capture cycle cancels it and restarts settling
  assign cap_go  = !changed && (state_q == SETTLE) && (stab_cnt_q == CNT_LAST);
  assign cap_wr  = cap_go && (sel_d != 4'b0000);

  // Segment pattern {g,f,e,d,c,b,a} (active-low) to glyph code
  always_comb begin
    glyph_d = CODE_BAD;
    case (samp_q[7:1])
      7'b1000000: glyph_d = 5'h00;
      7'b1111001: glyph_d = 5'h01;
      7'b0100100: glyph_d = 5'h02;
      7'b0110000: glyph_d = 5'h03;
      7'b0011001: glyph_d = 5'h04;
      7'b0010010: glyph_d = 5'h05;
      7'b0000010: glyph_d = 5'h06;
      7'b1111000: glyph_d = 5'h07;
      7'b0000000: glyph_d = 5'h08;
      7'b0010000: glyph_d = 5'h09;
      7'b0001000: glyph_d = 5'h0A;
      7'b0000011: glyph_d = 5'h0B;
      7'b1000110: glyph_d = 5'h0C;
      7'b0100001: glyph_d = 5'h0D;
      7'b0000110: glyph_d = 5'h0E;
      7'b0001110: glyph_d = 5'h0F;
      7'b1111111: glyph_d = 5'h10;
      7'b1000111: glyph_d = 5'h11;
      7'b1000001: glyph_d = 5'h12;
      default:    glyph_d = CODE_BAD;
    endcase
  end

  // Stability FSM with registered strobe, select and error counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= HELD;
      stab_cnt_q <= '0;
      strobe_q   <= 1'b0;
      sel_q      <= 4'b0000;
      err_q      <= 8'h00;
    end else begin
      strobe_q <= 1'b0;
      if (changed) begin
        state_q    <= SETTLE;
        stab_cnt_q <= '0;
      end else if (state_q == SETTLE) begin
        stab_cnt_q <= stab_cnt_q + 1'b1;
        if (cap_go) begin
          state_q <= HELD;
          if (cap_wr) begin
            strobe_q <= 1'b1;
            sel_q    <= sel_d;
            if ((glyph_d == CODE_BAD) && (err_q != 8'hFF)) begin
              err_q <= err_q + 8'h01;
            end
          end
        end
      end
    end
  end

  assign cap_strobe = strobe_q;
  assign cap_sel    = sel_q;
  assign err_cnt    = err_q;

  // Per-digit storage and ageing
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [4:0]              code_q;
    logic                    dp_q;
    logic                    valid_q;
    logic [TIMEOUT_BITS-1:0] age_q;

    // Write on capture, otherwise age and drop valid once the age saturates
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        code_q  <= 5'h10;
        dp_q    <= 1'b0;
        valid_q <= 1'b0;
        age_q   <= '0;
      end else if (cap_wr && sel_d[gi]) begin
        code_q  <= glyph_d;
        dp_q    <= samp_q[0];
        valid_q <= 1'b1;
        age_q   <= '0;
      end else begin
        if (age_q != AGE_MAX) begin
          age_q <= age_q + TIMEOUT_BITS'(1);
        end
        if (age_q >= AGE_WARN) begin
          valid_q <= 1'b0;
        end
      end
    end

    assign digit_code[5*gi +: 5] = code_q;
    assign digit_dp[gi]          = dp_q;
    assign digit_valid[gi]       = valid_q;
  end

endmodule

// File: tb/tb_seg_display_capture.sv
// Bench for seg_display_capture: expected captures are queued when a
// stimulus is driven and compared when the DUT raises cap_strobe.
module tb_seg_display_capture;

  localparam int STABLE = 16;
  localparam int TBITS  = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [19:0] digit_code;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_dp;
  logic        cap_strobe;
  logic [3:0]  cap_sel;
  logic [7:0]  err_cnt;

  typedef struct {
    logic [3:0] sel;
    logic [4:0] code;
    logic       dp;
    logic [7:0] err;
    int         edge_no;
  } exp_t;

  exp_t sb_q[$];
  int   edge_n = 0;
  int   total  = 0;
  int   bad    = 0;
  int   cap_edge;

  seg_display_capture #(
    .STABLE_CYCLES(STABLE),
    .TIMEOUT_BITS (TBITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .digit_code (digit_code),
    .digit_valid(digit_valid),
    .digit_dp   (digit_dp),
    .cap_strobe (cap_strobe),
    .cap_sel    (cap_sel),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n = edge_n + 1;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Apply a new bus value just after a falling edge; the next rising edge samples it
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d);
    @(negedge clk);
    an  = a;
    seg = s;
    dp  = d;
  endtask

  // Queue the capture expected for the value just driven
  task automatic expect_cap(input logic [3:0] sel, input logic [4:0] code,
                            input logic d, input logic [7:0] err);
    exp_t e;
    e.sel     = sel;
    e.code    = code;
    e.dp      = d;
    e.err     = err;
    e.edge_no = edge_n + 1 + STABLE;
    sb_q.push_back(e);
  endtask

  // Monitor: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (reset === 1'b1 && cap_strobe === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk_val("spurious_strobe", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("capture edge=%0d sel=%b code=%h dp=%b err=%0d", edge_n, cap_sel,
                 digit_code, digit_dp, err_cnt);
        chk_val("cap_edge", edge_n, e.edge_no);
        chk_val("cap_sel", {28'd0, cap_sel}, {28'd0, e.sel});
        chk_val("err_cnt", {24'd0, err_cnt}, {24'd0, e.err});
        for (int i = 0; i < 4; i++) begin
          if (e.sel[i]) begin
            chk_val($sformatf("code%0d", i), {27'd0, digit_code[5*i +: 5]}, {27'd0, e.code});
            chk_val($sformatf("dp%0d", i), {31'd0, digit_dp[i]}, {31'd0, e.dp});
            chk_val($sformatf("valid%0d", i), {31'd0, digit_valid[i]}, 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    an    = 4'hF;
    seg   = 7'h7F;
    dp    = 1'b0;
    repeat (3) @(negedge clk);
    chk_val("rst_code",   {12'd0, digit_code}, {12'd0, 20'h84210});
    chk_val("rst_valid",  {28'd0, digit_valid}, 32'd0);
    chk_val("rst_dp",     {28'd0, digit_dp}, 32'd0);
    chk_val("rst_strobe", {31'd0, cap_strobe}, 32'd0);
    chk_val("rst_sel",    {28'd0, cap_sel}, 32'd0);
    chk_val("rst_err",    {24'd0, err_cnt}, 32'd0);
    reset = 1'b1;
    // Idle bus (no anode active) settles with no strobe
    repeat (20) @(negedge clk);

    // 1: digit 2 shows '2'
    drive(4'b1011, 7'b0100100, 1'b0);
    expect_cap(4'b0100, 5'h02, 1'b0, 8'd0);
    repeat (20) @(negedge clk);
    chk_val("t1_valid", {28'd0, digit_valid}, 32'h4);
    chk_val("t1_sel_held", {28'd0, cap_sel}, 32'h4);

    // 2: short glitch on digit 3, then a stable '3'
    drive(4'b0111, 7'b1111001, 1'b0);
    repeat (9) @(negedge clk);
    drive(4'b0111, 7'b0110000, 1'b0);
    expect_cap(4'b1000, 5'h03, 1'b0, 8'd0);
    repeat (20) @(negedge clk);

    // 3: two digits at once, 'U' with dp set
    drive(4'b1100, 7'b1000001, 1'b1);
    expect_cap(4'b0011, 5'h12, 1'b1, 8'd0);
    repeat (20) @(negedge clk);

    // 4: undecodable pattern counts once even when held long
    drive(4'b1110, 7'b0110110, 1'b0);
    expect_cap(4'b0001, 5'h1F, 1'b0, 8'd1);
    repeat (100) @(negedge clk);
    chk_val("t4_err_hold", {24'd0, err_cnt}, 32'd1);
    chk_val("t4_code0", {27'd0, digit_code[4:0]}, 32'h1F);

    // 5: digit 3 shows '7', then no anode; digit 3 goes stale 63 cycles later
    drive(4'b0111, 7'b1111000, 1'b0);
    cap_edge = edge_n + 1 + STABLE;
    expect_cap(4'b1000, 5'h07, 1'b0, 8'd1);
    repeat (20) @(negedge clk);
    drive(4'b1111, 7'b1111000, 1'b0);
    while (edge_n < cap_edge + 62) @(negedge clk);
    chk_val("t5_valid_before", {31'd0, digit_valid[3]}, 32'd1);
    @(negedge clk);
    chk_val("t5_valid_stale", {31'd0, digit_valid[3]}, 32'd0);
    chk_val("t5_code_kept", {27'd0, digit_code[19:15]}, 32'h07);
    chk_val("t5_code2_kept", {27'd0, digit_code[14:10]}, 32'h02);

    // 6: reset in the middle of settling discards it
    drive(4'b1011, 7'b0100100, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_val("t6_rst_code",   {12'd0, digit_code}, {12'd0, 20'h84210});
    chk_val("t6_rst_valid",  {28'd0, digit_valid}, 32'd0);
    chk_val("t6_rst_err",    {24'd0, err_cnt}, 32'd0);
    chk_val("t6_rst_sel",    {28'd0, cap_sel}, 32'd0);
    chk_val("t6_rst_strobe", {31'd0, cap_strobe}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    expect_cap(4'b0100, 5'h02, 1'b0, 8'd0);
    repeat (20) @(negedge clk);
    chk_val("t6_valid", {28'd0, digit_valid}, 32'h4);

    repeat (5) @(negedge clk);
    chk_val("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
